axi_bram_log_reader: RTL

Drains log entries written by the AXI BRAM logger out of its true-dual-port BRAM array. It uses the second port as a read-only master and serializes each 96-bit entry into three 32-bit words on a valid/ready stream, for example toward a DMA or debug FIFO. A single start command reads a requested number of entries from entry 0 upward. On completion the block pulses a clear request, so the logger can wipe and re-arm the log.

---
 rtl/axi_bram_log_pkg.sv | 46 ++++
 rtl/log_entry_serializer.sv | 66 ++++++
 rtl/axi_bram_log_reader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/axi_bram_log_pkg.sv
`default_nettype none
// ============================================================================
// axi_bram_log_pkg: log-entry layout, field positions and reader FSM states
// Revision: 1.0
// ============================================================================
package axi_bram_log_pkg;

  localparam int LOGGING_DATA_BITW = 96;
  localparam int LOG_WORD_BITW     = 32;

  localparam int TIMESTAMP_LOW     = 0;
  localparam int TIMESTAMP_HIGH    = 31;
  localparam int AXI_ADDR_LOW      = 32;
  localparam int AXI_ADDR_HIGH     = 63;
  localparam int AXI_LEN_LOW       = 64;
  localparam int AXI_LEN_HIGH      = 71;
  localparam int AXI_ID_LOW        = 72;
  localparam int AXI_ID_MAX_BITW   = 24;

  // id is sized for the widest logger; unused upper id bits read as zero
  typedef struct packed {
    logic [AXI_ID_MAX_BITW-1:0]              id;
    logic [AXI_LEN_HIGH-AXI_LEN_LOW:0]       len;
    logic [AXI_ADDR_HIGH-AXI_ADDR_LOW:0]     addr;
    logic [TIMESTAMP_HIGH-TIMESTAMP_LOW:0]   timestamp;
  } log_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SEND   = 3'd3,
    ST_FINISH = 3'd4
  } reader_state_e;

  function automatic log_entry_t mask_entry(input logic [LOGGING_DATA_BITW-1:0] raw,
                                            input int keep_bitw);
    logic [LOGGING_DATA_BITW-1:0] m;
    for (int i = 0; i < LOGGING_DATA_BITW; i++) begin
      m[i] = raw[i] & (i < keep_bitw);
    end
    return log_entry_t'(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/log_entry_serializer.sv
`default_nettype none
// ============================================================================
// log_entry_serializer: splits one 96-bit log entry into three 32-bit stream words
// Revision: 1.0
// ============================================================================
module log_entry_serializer
  import axi_bram_log_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     load_i,
  input  log_entry_t               entry_i,
  input  logic                     last_i,
  output logic                     done_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [LOG_WORD_BITW-1:0] data_o,
  output logic                     last_o
);

  log_entry_t entry_q;
  logic       last_q;
  logic       valid_q;
  logic [1:0] word_q;
  logic       fire;

  assign fire   = valid_q && ready_i;
  assign done_o = fire && (word_q == 2'd2);

  // The caller loads only while empty or on the final-word handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      entry_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      word_q  <= 2'd0;
    end else if (load_i) begin
      entry_q <= entry_i;
      last_q  <= last_i;
      valid_q <= 1'b1;
      word_q  <= 2'd0;
    end else if (fire) begin
      if (word_q == 2'd2) begin
        valid_q <= 1'b0;
        word_q  <= 2'd0;
      end else begin
        word_q  <= word_q + 2'd1;
      end
    end
  end

  always_comb begin
    data_o = entry_q.timestamp;
    case (word_q)
      2'd0:    data_o = entry_q.timestamp;
      2'd1:    data_o = entry_q.addr;
      default: data_o = entry_q[LOGGING_DATA_BITW-1:AXI_LEN_LOW];
    endcase
  end

  assign valid_o = valid_q;
  assign last_o  = valid_q && last_q && (word_q == 2'd2);

endmodule
`default_nettype wire

// File: rtl/axi_bram_log_reader.sv
`default_nettype none
// ============================================================================
// axi_bram_log_reader: drains logger BRAM entries onto a 32-bit stream.
// Optional AXI_BRAM_LOG_READER_PREFETCH_EN adds a second entry buffer for gap-free output.
// Revision: 1.0
// ============================================================================
module axi_bram_log_reader
  import axi_bram_log_pkg::*;
#(
  parameter  int AXI_ID_BITW     = 8,
  parameter  int AXI_LEN_BITW    = 8,
  parameter  int NUM_LOG_ENTRIES = 16384,
  localparam int CNT_BITW        = $clog2(NUM_LOG_ENTRIES)
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_RI,
  input  logic                         Start_SI,
  input  logic [CNT_BITW:0]            NumEntries_DI,
  input  logic                         Abort_SI,
  output logic                         Busy_SO,
  output logic                         Done_SO,
  output logic                         ClearReq_SO,
  output logic                         BramEn_SO,
  output logic [CNT_BITW-1:0]          BramAddr_DO,
  input  logic [LOGGING_DATA_BITW-1:0] BramRd_DI,
  output logic                         OutValid_SO,
  input  logic                         OutReady_SI,
  output logic [LOG_WORD_BITW-1:0]     OutData_DO,
  output logic                         OutLast_SO
);

  localparam int                KEEP_BITW = AXI_LEN_LOW + AXI_LEN_BITW + AXI_ID_BITW;
  localparam logic [CNT_BITW:0] MAX_N     = (CNT_BITW+1)'(NUM_LOG_ENTRIES);

  reader_state_e       state_q;
  logic                busy_q;
  logic                done_q;
  logic                en_q;
  logic [CNT_BITW-1:0] addr_q;
  logic [CNT_BITW-1:0] idx_q;
  logic [CNT_BITW-1:0] last_idx_q;

  logic                abort;
  logic [CNT_BITW:0]   n_start;
  log_entry_t          rd_entry;
  logic                ser_load;
  log_entry_t          ser_data;
  logic                ser_last;
  logic                ser_done;

  assign abort    = Abort_SI && (state_q != ST_IDLE);
  assign n_start  = (NumEntries_DI > MAX_N) ? MAX_N : NumEntries_DI;
  assign rd_entry = mask_entry(BramRd_DI, KEEP_BITW);

`ifdef AXI_BRAM_LOG_READER_PREFETCH_EN
  log_entry_t pf_q;
  logic       pf_pend_q;

  // After the first entry, each reload comes from the prefetch buffer on the w2 handshake.
  assign ser_load = (state_q == ST_WAIT) ||
                    ((state_q == ST_SEND) && ser_done && (idx_q != last_idx_q));
  assign ser_data = (state_q == ST_WAIT) ? rd_entry : pf_q;
  assign ser_last = (state_q == ST_WAIT) ? (idx_q == last_idx_q)
                                         : ((idx_q + CNT_BITW'(1)) == last_idx_q);
`else
  assign ser_load = (state_q == ST_WAIT);
  assign ser_data = rd_entry;
  assign ser_last = (idx_q == last_idx_q);
`endif

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
`ifdef AXI_BRAM_LOG_READER_PREFETCH_EN
      pf_q       <= '0;
      pf_pend_q  <= 1'b0;
`endif
    end else if (abort) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
`ifdef AXI_BRAM_LOG_READER_PREFETCH_EN
      pf_pend_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      en_q   <= 1'b0;
`ifdef AXI_BRAM_LOG_READER_PREFETCH_EN
      pf_pend_q <= en_q && (state_q == ST_SEND);
      if (pf_pend_q) begin
        pf_q <= rd_entry;
      end
`endif
      case (state_q)
        ST_IDLE: begin
          if (Start_SI) begin
            busy_q     <= 1'b1;
            idx_q      <= '0;
            last_idx_q <= CNT_BITW'(n_start - (CNT_BITW+1)'(1));
            if (n_start == '0) begin
              state_q <= ST_FINISH;
            end else begin
              state_q <= ST_FETCH;
              en_q    <= 1'b1;
              addr_q  <= '0;
            end
          end
        end
        ST_FETCH: state_q <= ST_WAIT;
        ST_WAIT: begin
          state_q <= ST_SEND;
`ifdef AXI_BRAM_LOG_READER_PREFETCH_EN
          if (idx_q != last_idx_q) begin
            en_q   <= 1'b1;
            addr_q <= idx_q + CNT_BITW'(1);
          end
`endif
        end
        ST_SEND: begin
          if (ser_done) begin
            if (idx_q == last_idx_q) begin
              state_q <= ST_FINISH;
            end else begin
              idx_q <= idx_q + CNT_BITW'(1);
`ifdef AXI_BRAM_LOG_READER_PREFETCH_EN
              if ((idx_q + CNT_BITW'(1)) != last_idx_q) begin
                en_q   <= 1'b1;
                addr_q <= idx_q + CNT_BITW'(2);
              end
`else
              state_q <= ST_FETCH;
              en_q    <= 1'b1;
              addr_q  <= idx_q + CNT_BITW'(1);
`endif
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  log_entry_serializer u_serializer (
    .clk_i   (Clk_CI),
    .rst_i   (Rst_RI),
    .flush_i (abort),
    .load_i  (ser_load),
    .entry_i (ser_data),
    .last_i  (ser_last),
    .done_o  (ser_done),
    .valid_o (OutValid_SO),
    .ready_i (OutReady_SI),
    .data_o  (OutData_DO),
    .last_o  (OutLast_SO)
  );

  assign Busy_SO     = busy_q;
  assign Done_SO     = done_q;
  assign ClearReq_SO = done_q;
  assign BramEn_SO   = en_q;
  assign BramAddr_DO = addr_q;

endmodule
`default_nettype wire
